level_fifo: RTL and testbench

Synchronous single-clock FIFO with valid/ready ports on both sides; next generation of the team's simple FIFO. Unlike its predecessor it uses all 2**ASIZE entries through an extra pointer wrap bit, and it reports its fill level and programmable almost-full/almost-empty watermarks. It sits between the bus-side register interface and the LED-stream engines, where software and flow control need occupancy information.

---
 rtl/level_fifo_pkg.sv | 36 +++
 rtl/level_fifo_mem.sv | 25 ++
 rtl/level_fifo.sv | 118 +++++++++++
 tb/tb_level_fifo.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/level_fifo_pkg.sv
// Shared helpers for level_fifo: level width, pointer full/empty compare and
// threshold range-check macros used at elaboration.
`ifndef LEVEL_FIFO_PKG_SV
`define LEVEL_FIFO_PKG_SV

`define LEVEL_FIFO_AFULL_TH_OK(th, asize)  (((th) >= 1) && ((th) <= (1 << (asize))))
`define LEVEL_FIFO_AEMPTY_TH_OK(th, asize) (((th) >= 0) && ((th) <= ((1 << (asize)) - 1)))

package level_fifo_pkg;

    localparam int PTR_MAX_W = 32;

    function automatic int level_w(input int asize);
        return asize + 1;
    endfunction

    // Pointers carry one wrap bit above the address bits.
    function automatic logic ptr_full(input logic [PTR_MAX_W-1:0] wr_ptr,
                                      input logic [PTR_MAX_W-1:0] rd_ptr,
                                      input int unsigned asize);
        logic [PTR_MAX_W-1:0] mask;
        mask = (32'd1 << asize) - 32'd1;
        return ((wr_ptr & mask) == (rd_ptr & mask)) && (wr_ptr[asize] != rd_ptr[asize]);
    endfunction

    function automatic logic ptr_empty(input logic [PTR_MAX_W-1:0] wr_ptr,
                                       input logic [PTR_MAX_W-1:0] rd_ptr,
                                       input int unsigned asize);
        logic [PTR_MAX_W-1:0] mask;
        mask = (32'd1 << (asize + 1)) - 32'd1;
        return (wr_ptr & mask) == (rd_ptr & mask);
    endfunction

endpackage

`endif

// File: rtl/level_fifo_mem.sv
// Storage array for level_fifo: one synchronous write port, one asynchronous
// read port, kept separate so a foundry macro can replace it.
module level_fifo_mem #(
    parameter int ASIZE = 4,
    parameter int DSIZE = 32
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [ASIZE-1:0] wr_addr,
    input  logic [DSIZE-1:0] wr_data,
    input  logic [ASIZE-1:0] rd_addr,
    output logic [DSIZE-1:0] rd_data
);

    logic [DSIZE-1:0] mem [2**ASIZE];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/level_fifo.sv
// Single-clock FWFT FIFO using all 2**ASIZE entries, with a registered fill level
// and watermarks. Define LEVEL_FIFO_PEAK_EN to add the peak_level high-water mark.
module level_fifo
    import level_fifo_pkg::*;
#(
    parameter int ASIZE     = 4,
    parameter int DSIZE     = 32,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_n,
    input  logic [DSIZE-1:0] wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [DSIZE-1:0] rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [ASIZE:0]   level,
    output logic             almost_full,
    output logic             almost_empty
`ifdef LEVEL_FIFO_PEAK_EN
    ,
    output logic [ASIZE:0]   peak_level
`endif
);

    localparam int LW = level_w(ASIZE);
    localparam logic [LW-1:0] AFULL_LV  = LW'(AFULL_TH);
    localparam logic [LW-1:0] AEMPTY_LV = LW'(AEMPTY_TH);

    if (!`LEVEL_FIFO_AFULL_TH_OK(AFULL_TH, ASIZE)) begin : g_bad_afull_th
        $error("level_fifo: AFULL_TH outside 1..2**ASIZE");
    end
    if (!`LEVEL_FIFO_AEMPTY_TH_OK(AEMPTY_TH, ASIZE)) begin : g_bad_aempty_th
        $error("level_fifo: AEMPTY_TH outside 0..2**ASIZE-1");
    end

    logic [LW-1:0] wr_ptr;
    logic [LW-1:0] rd_ptr;
    logic [LW-1:0] level_nxt;
    logic          full;
    logic          empty;
    logic          wr_fire;
    logic          rd_fire;

    assign full     = ptr_full(PTR_MAX_W'(wr_ptr), PTR_MAX_W'(rd_ptr), ASIZE);
    assign empty    = ptr_empty(PTR_MAX_W'(wr_ptr), PTR_MAX_W'(rd_ptr), ASIZE);
    assign wr_ready = !full;
    assign rd_valid = !empty;

    // A clear cycle swallows both transfers, including the memory write.
    assign wr_fire = wr_valid && wr_ready && clear_n;
    assign rd_fire = rd_valid && rd_ready && clear_n;

    always_comb begin
        level_nxt = level;
        if (wr_fire && !rd_fire) begin
            level_nxt = level + LW'(1);
        end else if (rd_fire && !wr_fire) begin
            level_nxt = level - LW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (!clear_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + LW'(1);
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + LW'(1);
            end
            level <= level_nxt;
        end
    end

    assign almost_full  = (level >= AFULL_LV);
    assign almost_empty = (level <= AEMPTY_LV);

`ifdef LEVEL_FIFO_PEAK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_level <= '0;
        end else if (!clear_n) begin
            peak_level <= '0;
        end else if (level_nxt > peak_level) begin
            peak_level <= level_nxt;
        end
    end
`endif

    level_fifo_mem #(
        .ASIZE(ASIZE),
        .DSIZE(DSIZE)
    ) u_mem (
        .clk    (clk),
        .wr_en  (wr_fire),
        .wr_addr(wr_ptr[ASIZE-1:0]),
        .wr_data(wr_data),
        .rd_addr(rd_ptr[ASIZE-1:0]),
        .rd_data(rd_data)
    );

`ifndef SYNTHESIS
    level_tracks_ptrs: assert property (@(posedge clk) disable iff (!rst_n)
        level == LW'(wr_ptr - rd_ptr));
`endif

endmodule

// File: tb/tb_level_fifo.sv
// Scoreboard bench for level_fifo (ASIZE=4, DSIZE=32, AFULL_TH=12, AEMPTY_TH=2).
module tb_level_fifo;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear_n;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [4:0]  level;
    logic        almost_full;
    logic        almost_empty;
`ifdef LEVEL_FIFO_PEAK_EN
    logic [4:0]  peak_level;
`endif

    int          total = 0;
    int          bad = 0;
    int          m_level = 0;
    int          m_peak = 0;
    logic [31:0] sb [$];

    always #5 clk = ~clk;

    level_fifo #(
        .ASIZE(4),
        .DSIZE(32),
        .AFULL_TH(12),
        .AEMPTY_TH(2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_n     (clear_n),
        .wr_data     (wr_data),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .level       (level),
        .almost_full (almost_full),
        .almost_empty(almost_empty)
`ifdef LEVEL_FIFO_PEAK_EN
        ,
        .peak_level  (peak_level)
`endif
    );

    // One clock of stimulus; updates the model and returns the word the read should see.
    task automatic step(input logic wv, input logic [31:0] wd, input logic rr,
                        output logic rd_acc, output logic [31:0] exp_d, output logic [31:0] got_d);
        logic wr_acc;
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        #1;
        wr_acc = wv && (m_level < DEPTH);
        rd_acc = rr && (m_level > 0);
        got_d  = rd_data;
        exp_d  = '0;
        if (rd_acc) exp_d = sb.pop_front();
        if (wr_acc) sb.push_back(wd);
        m_level = m_level + int'(wr_acc) - int'(rd_acc);
        if (m_level > m_peak) m_peak = m_level;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear_n = 1'b1; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        total++; if (level !== 5'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
        total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL reset_afull got=%b exp=0", almost_full); end
        total++; if (almost_empty !== 1'b1) begin bad++; $display("FAIL reset_aempty got=%b exp=1", almost_empty); end
`ifdef LEVEL_FIFO_PEAK_EN
        total++; if (peak_level !== 5'd0) begin bad++; $display("FAIL reset_peak got=%0d exp=0", peak_level); end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        logic ra; logic [31:0] e, g;
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 32'h1000_0000 + 32'(i), 1'b0, ra, e, g);
            total++; if (level !== 5'(m_level)) begin bad++; $display("FAIL fill_level got=%0d exp=%0d", level, m_level); end
            total++; if (almost_full !== (i + 1 >= 12)) begin bad++; $display("FAIL fill_afull level=%0d got=%b", i + 1, almost_full); end
            total++; if (wr_ready !== (i + 1 < DEPTH)) begin bad++; $display("FAIL fill_wr_ready level=%0d got=%b", i + 1, wr_ready); end
            total++; if (almost_empty !== (i + 1 <= 2)) begin bad++; $display("FAIL fill_aempty level=%0d got=%b", i + 1, almost_empty); end
        end
        total++; if (level !== 5'd16) begin bad++; $display("FAIL fill_final_level got=%0d exp=16", level); end
    endtask

    task automatic test_drain();
        logic ra; logic [31:0] e, g;
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, '0, 1'b1, ra, e, g);
            total++; if (!ra || g !== e) begin bad++; $display("FAIL drain_data idx=%0d got=%h exp=%h", i, g, e); end
            total++; if (g !== 32'h1000_0000 + 32'(i)) begin bad++; $display("FAIL drain_order idx=%0d got=%h exp=%h", i, g, 32'h1000_0000 + 32'(i)); end
        end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL drain_rd_valid got=%b exp=0", rd_valid); end
        total++; if (almost_empty !== 1'b1) begin bad++; $display("FAIL drain_aempty got=%b exp=1", almost_empty); end
        total++; if (level !== 5'd0) begin bad++; $display("FAIL drain_level got=%0d exp=0", level); end
    endtask

    task automatic test_full_simul();
        logic ra; logic [31:0] e, g;
        step(1'b1, 32'h2000_0000, 1'b1, ra, e, g);
        total++; if (!ra || g !== e) begin bad++; $display("FAIL fullsim_data got=%h exp=%h", g, e); end
        total++; if (level !== 5'd15) begin bad++; $display("FAIL fullsim_level got=%0d exp=15", level); end
        step(1'b1, 32'h2000_0001, 1'b0, ra, e, g);
        total++; if (level !== 5'd16) begin bad++; $display("FAIL fullsim_refill got=%0d exp=16", level); end
        total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL fullsim_wr_ready got=%b exp=0", wr_ready); end
    endtask

    task automatic test_random();
        logic ra; logic [31:0] e, g;
        for (int i = 0; i < 1000; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), ra, e, g);
            if (ra) begin
                total++; if (g !== e) begin bad++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", i, g, e); end
            end
            total++; if (level !== 5'(m_level)) begin bad++; $display("FAIL rand_level cyc=%0d got=%0d exp=%0d", i, level, m_level); end
            total++; if (wr_ready !== (m_level < DEPTH) || rd_valid !== (m_level > 0)) begin
                bad++; $display("FAIL rand_flags cyc=%0d got=%b%b exp=%b%b", i, wr_ready, rd_valid, m_level < DEPTH, m_level > 0);
            end
        end
        while (m_level > 0) begin
            step(1'b0, '0, 1'b1, ra, e, g);
            total++; if (g !== e) begin bad++; $display("FAIL rand_tail got=%h exp=%h", g, e); end
        end
    endtask

    task automatic test_clear();
        logic ra; logic [31:0] e, g;
        for (int i = 0; i < 5; i++) step(1'b1, 32'h3000_0000 + 32'(i), 1'b0, ra, e, g);
        total++; if (level !== 5'd5) begin bad++; $display("FAIL clear_pre_level got=%0d exp=5", level); end
        clear_n = 1'b0; wr_valid = 1'b1; wr_data = 32'hDEAD_BEEF; rd_ready = 1'b1;
        @(posedge clk); #1;
        clear_n = 1'b1; wr_valid = 1'b0; rd_ready = 1'b0;
        sb.delete(); m_level = 0; m_peak = 0;
        total++; if (level !== 5'd0) begin bad++; $display("FAIL clear_level got=%0d exp=0", level); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL clear_rd_valid got=%b exp=0", rd_valid); end
        step(1'b1, 32'hA5A5_A5A5, 1'b0, ra, e, g);
        step(1'b0, '0, 1'b1, ra, e, g);
        total++; if (!ra || g !== 32'hA5A5_A5A5) begin bad++; $display("FAIL clear_first_word got=%h exp=a5a5a5a5", g); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL clear_after_rd_valid got=%b exp=0", rd_valid); end
    endtask

`ifdef LEVEL_FIFO_PEAK_EN
    task automatic test_peak();
        logic ra; logic [31:0] e, g;
        clear_n = 1'b0; @(posedge clk); #1; clear_n = 1'b1;
        sb.delete(); m_level = 0; m_peak = 0;
        total++; if (peak_level !== 5'd0) begin bad++; $display("FAIL peak_clear0 got=%0d exp=0", peak_level); end
        for (int i = 0; i < 9; i++) step(1'b1, 32'(i), 1'b0, ra, e, g);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, ra, e, g);
        for (int i = 0; i < 4; i++) step(1'b1, 32'(i), 1'b0, ra, e, g);
        total++; if (level !== 5'd7) begin bad++; $display("FAIL peak_level_now got=%0d exp=7", level); end
        total++; if (peak_level !== 5'd9 || m_peak != 9) begin bad++; $display("FAIL peak_hwm got=%0d exp=9", peak_level); end
        clear_n = 1'b0; @(posedge clk); #1; clear_n = 1'b1;
        sb.delete(); m_level = 0; m_peak = 0;
        total++; if (peak_level !== 5'd0) begin bad++; $display("FAIL peak_clear got=%0d exp=0", peak_level); end
    endtask
`endif

    task automatic test_async_reset();
        logic ra; logic [31:0] e, g;
        for (int i = 0; i < 4; i++) step(1'b1, 32'h4000_0000 + 32'(i), 1'b0, ra, e, g);
        wr_valid = 1'b1; wr_data = 32'h4000_00FF;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL arst_wr_ready got=%b exp=1", wr_ready); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL arst_rd_valid got=%b exp=0", rd_valid); end
        total++; if (level !== 5'd0) begin bad++; $display("FAIL arst_level got=%0d exp=0", level); end
        total++; if (almost_full !== 1'b0 || almost_empty !== 1'b1) begin
            bad++; $display("FAIL arst_almost got=%b%b exp=01", almost_full, almost_empty);
        end
`ifdef LEVEL_FIFO_PEAK_EN
        total++; if (peak_level !== 5'd0) begin bad++; $display("FAIL arst_peak got=%0d exp=0", peak_level); end
`endif
        @(posedge clk); #1;
        rst_n = 1'b1; wr_valid = 1'b0;
        sb.delete(); m_level = 0; m_peak = 0;
        step(1'b1, 32'h5555_AAAA, 1'b0, ra, e, g);
        step(1'b0, '0, 1'b1, ra, e, g);
        total++; if (!ra || g !== 32'h5555_AAAA) begin bad++; $display("FAIL arst_after got=%h exp=5555aaaa", g); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_fill();
        test_full_simul();
        test_random();
        test_clear();
`ifdef LEVEL_FIFO_PEAK_EN
        test_peak();
`endif
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
